pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit; successor to the fixed 32-bit PC register. Sits at the head of the IF stage: generates the instruction fetch address and chip enable for instruction memory. Adds a programmable reset vector, a fetch-ready handshake, a pipeline-flush redirect and a pending-redirect buffer, so that branches arriving while IF is stalled are not lost.

## Interface
- ADDR_W, 32, PC and target width in bits
- RESET_VECTOR, 0, PC value held during and after reset
- INST_BYTES, 4, sequential increment; power of two, at least 1
- STALL_W, 6, width of the pipeline stall vector; only bit 0 is used
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  STALL_W  pipeline stall vector; stall[0]=1 freezes the PC
- fetch_ack_i  in  1  instruction memory accepted the current fetch_addr_o
- branch_flag_i  in  1  branch taken, from ID
- branch_target_i  in  ADDR_W  branch target
- flush_i  in  1  exception/eret flush
- flush_target_i  in  ADDR_W  flush target
- pc_o  out  ADDR_W  current PC, which is also the fetch address
- ce_o  out  1  instruction memory chip enable
- fetch_req_o  out  1  fetch request; equal to ce_o, combinational
- redirect_pending_o  out  1  a buffered redirect is waiting
- misalign_o  out  1  pc_o not aligned to INST_BYTES; only when ALIGN_CHECK is compiled in

## Operation
- ce_o register: rst=1 → 0; otherwise → 1. While ce_o=0, pc_o is forced to RESET_VECTOR and pending is cleared.
- Advance condition: adv = ce_o & ~stall[0] & fetch_ack_i.
- Next-PC priority, highest first:
  - rst → RESET_VECTOR
  - flush_i & ce_o → flush_target_i. Applies regardless of stall and ack. Clears pending.
  - adv & branch_flag_i → branch_target_i. Clears pending.
  - adv & pending_valid → pending_target. Clears pending.
  - adv → pc_o + INST_BYTES, modulo 2^ADDR_W (wraps to 0, no flag).
  - otherwise → hold.
- Pending capture:
  - Condition: branch_flag_i & ce_o & ~adv & ~flush_i.
  - Action: pending_valid←1 and pending_target←branch_target_i.
  - A later capture overwrites the earlier one, since ID holds the same branch while stalled.
- Simultaneous flush and branch: flush wins and the branch is discarded (not buffered).
- redirect_pending_o = pending_valid (registered).

## Timing
- Reset values: pc_o=RESET_VECTOR, ce_o=0, pending_valid=0, pending_target=0, misalign_o=0.
- ce_o rises on the first edge at which rst=0. In that cycle pc_o=RESET_VECTOR is presented for fetch.
- Latency: one cycle from an accepted fetch (adv=1) to the next pc_o. The same one cycle applies from flush_i to pc_o=flush_target_i.
- A branch seen in a stalled cycle appears on pc_o one cycle after the first adv cycle.
- rst mid-operation wins over all events; it takes effect at the same edge.
- Back-to-back adv cycles give one new PC per cycle. fetch_ack_i=0 holds pc_o stable, as stall does.

## Configuration
- Macro: PC_UNIT_ALIGN_CHECK_EN.
- Defined:
  - misalign_o is a register, set when the next pc_o has any of its low log2(INST_BYTES) bits nonzero.
  - Cleared by rst or by the next aligned pc_o.
  - The PC still loads the unaligned target verbatim; the exception is raised downstream.
- Undefined: misalign_o is tied to 0 and has no register.

## Structure
- Shared package / define.v holds:
  - RESET_VECTOR default
  - INST_BYTES
  - the stall bit index for IF (0)
  - the ReadEnable/ReadDisable and Branch encodings
- Sub-module pc_redirect_buf holds pending_valid and pending_target:
  - inputs: capture, clear, target
  - outputs: valid, target
  - clear has priority over capture.

## Test plan
- Reset release, RESET_VECTOR=0xBFC00000, no stall, ack=1 → ce_o 0→1; pc_o sequence 0xBFC00000, 0xBFC00004, 0xBFC00008.
- Stall with branch: stall[0]=1 for 3 cycles, branch_flag_i=1 with target 0x100 in cycle 1 only, then release → redirect_pending_o=1 during the stall; pc_o=0x100 one cycle after release; pending then clears.
- Flush during stall: stall[0]=1 with pending branch 0x100, then flush_i=1 with target 0x380 → pc_o=0x380 next edge; pending cleared; after release pc_o=0x384.
- fetch_ack_i=0 for 2 cycles at pc_o=0x20 → pc_o holds 0x20; 0x24 after ack returns.
- Wrap: ADDR_W=16, pc_o=0xFFFC → next pc_o=0x0000.
- With PC_UNIT_ALIGN_CHECK_EN: branch target 0x102 → pc_o=0x102 with misalign_o=1; next sequential 0x106 keeps 1; flush to 0x200 clears it to 0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the IF-stage program-counter unit: default reset
// vector, instruction size, stall bit index and the enable/branch encodings.
package pc_unit_pkg;

    localparam logic [31:0]  RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int unsigned  INST_BYTES_DEFAULT   = 32'd4;
    localparam int unsigned  STALL_IF_BIT         = 32'd0;

    typedef enum logic {
        READ_DISABLE = 1'b0,
        READ_ENABLE  = 1'b1
    } read_en_e;

    typedef enum logic {
        NOT_BRANCH = 1'b0,
        BRANCH     = 1'b1
    } branch_e;

    typedef enum logic [2:0] {
        PC_SRC_HOLD    = 3'd0,
        PC_SRC_SEQ     = 3'd1,
        PC_SRC_BRANCH  = 3'd2,
        PC_SRC_PENDING = 3'd3,
        PC_SRC_FLUSH   = 3'd4,
        PC_SRC_RESET   = 3'd5
    } pc_src_e;

    // Low-bit mask that must be zero for an address aligned to `bytes`.
    function automatic logic [31:0] align_mask(input int unsigned bytes);
        return bytes - 32'd1;
    endfunction

endpackage

// File: rtl/pc_unit_redirect_buf.sv
// One-entry buffer holding a branch redirect that arrived while IF could not
// advance; clear takes priority over capture.
module pc_redirect_buf
    import pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32'd32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] target_o
);

    logic              valid_q;
    logic              valid_d;
    logic [ADDR_W-1:0] target_q;
    logic [ADDR_W-1:0] target_d;

    // Next-state for the buffered redirect; a newer capture overwrites the old one.
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (rst) begin
            valid_d  = 1'b0;
            target_d = '0;
        end else if (clear_i) begin
            valid_d  = 1'b0;
        end else if (capture_i) begin
            valid_d  = 1'b1;
            target_d = target_i;
        end else begin
            valid_d  = valid_q;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        valid_q  <= valid_d;
        target_q <= target_d;
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter with fetch handshake, flush/branch redirect and a
// pending-redirect buffer. Optional misalign flag: PC_UNIT_ALIGN_CHECK_EN.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32'd32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT),
    parameter int unsigned       INST_BYTES   = INST_BYTES_DEFAULT,
    parameter int unsigned       STALL_W      = 32'd6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               fetch_ack_i,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  flush_target_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               ce_o,
    output logic               fetch_req_o,
    output logic               redirect_pending_o,
    output logic               misalign_o
);

    read_en_e          ce_q;
    read_en_e          ce_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    pc_src_e           pc_src_s;
    logic              stall_if_s;
    logic              adv_s;
    logic              capture_s;
    logic              clear_s;
    logic              pend_valid_s;
    logic [ADDR_W-1:0] pend_target_s;
    logic              unused_stall_s;

    // Only the IF bit of the stall vector matters here.
    assign stall_if_s     = stall[STALL_IF_BIT];
    assign unused_stall_s = ^stall;

    assign adv_s = (ce_q == READ_ENABLE) && !stall_if_s && fetch_ack_i;

    // Flush discards a coincident branch, so it also blocks capture.
    assign capture_s = (branch_flag_i == BRANCH) && (ce_q == READ_ENABLE)
                       && !adv_s && !flush_i;
    assign clear_s   = (ce_q == READ_DISABLE) || flush_i || adv_s;

    // Next-PC source selection, highest priority first.
    always_comb begin
        pc_src_s = PC_SRC_HOLD;
        if (rst || (ce_q == READ_DISABLE)) begin
            pc_src_s = PC_SRC_RESET;
        end else if (flush_i) begin
            pc_src_s = PC_SRC_FLUSH;
        end else if (adv_s && (branch_flag_i == BRANCH)) begin
            pc_src_s = PC_SRC_BRANCH;
        end else if (adv_s && pend_valid_s) begin
            pc_src_s = PC_SRC_PENDING;
        end else if (adv_s) begin
            pc_src_s = PC_SRC_SEQ;
        end else begin
            pc_src_s = PC_SRC_HOLD;
        end
    end

    // Next-PC mux; the sequential add wraps silently at 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        case (pc_src_s)
            PC_SRC_RESET:   pc_d = RESET_VECTOR;
            PC_SRC_FLUSH:   pc_d = flush_target_i;
            PC_SRC_BRANCH:  pc_d = branch_target_i;
            PC_SRC_PENDING: pc_d = pend_target_s;
            PC_SRC_SEQ:     pc_d = pc_q + ADDR_W'(INST_BYTES);
            PC_SRC_HOLD:    pc_d = pc_q;
            default:        pc_d = RESET_VECTOR;
        endcase
    end

    // Chip enable drops only while reset is asserted.
    always_comb begin
        ce_d = READ_ENABLE;
        if (rst) begin
            ce_d = READ_DISABLE;
        end else begin
            ce_d = READ_ENABLE;
        end
    end

    // PC and chip-enable registers.
    always_ff @(posedge clk) begin
        pc_q <= pc_d;
        ce_q <= ce_d;
    end

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk       (clk),
        .rst       (rst),
        .capture_i (capture_s),
        .clear_i   (clear_s),
        .target_i  (branch_target_i),
        .valid_o   (pend_valid_s),
        .target_o  (pend_target_s)
    );

`ifdef PC_UNIT_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(INST_BYTES));

    logic misalign_q;
    logic misalign_d;

    // Flag tracks the PC being loaded; the target itself is never altered.
    always_comb begin
        misalign_d = 1'b0;
        if (rst) begin
            misalign_d = 1'b0;
        end else begin
            misalign_d = |(pc_d & ALIGN_MASK);
        end
    end

    // Misalign flag register, updated alongside the PC.
    always_ff @(posedge clk) begin
        misalign_q <= misalign_d;
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign pc_o               = pc_q;
    assign ce_o               = ce_q;
    assign fetch_req_o        = ce_q;
    assign redirect_pending_o = pend_valid_s;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table followed by random
// stimulus checked against a behavioural model; a 16-bit instance tracks the low half.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'hBFC0_0000;
`ifdef PC_UNIT_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        fetch_ack_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] flush_target_i;
    logic [31:0] pc_o;
    logic        ce_o;
    logic        fetch_req_o;
    logic        redirect_pending_o;
    logic        misalign_o;
    logic [15:0] pc16;
    logic        ce16;
    logic        req16;
    logic        pend16;
    logic        mis16;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_pv;
    logic [31:0] m_pt;
    logic        m_mis;

    typedef struct {
        logic        r;
        logic        s;
        logic        a;
        logic        b;
        logic [31:0] bt;
        logic        f;
        logic [31:0] ft;
        logic [31:0] e_pc;
        logic        e_ce;
        logic        e_pend;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pc_unit #(
        .ADDR_W       (32),
        .RESET_VECTOR (RV),
        .INST_BYTES   (4),
        .STALL_W      (6)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .fetch_ack_i        (fetch_ack_i),
        .branch_flag_i      (branch_flag_i),
        .branch_target_i    (branch_target_i),
        .flush_i            (flush_i),
        .flush_target_i     (flush_target_i),
        .pc_o               (pc_o),
        .ce_o               (ce_o),
        .fetch_req_o        (fetch_req_o),
        .redirect_pending_o (redirect_pending_o),
        .misalign_o         (misalign_o)
    );

    pc_unit #(
        .ADDR_W       (16),
        .RESET_VECTOR (16'h0000),
        .INST_BYTES   (4),
        .STALL_W      (6)
    ) u_dut16 (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .fetch_ack_i        (fetch_ack_i),
        .branch_flag_i      (branch_flag_i),
        .branch_target_i    (branch_target_i[15:0]),
        .flush_i            (flush_i),
        .flush_target_i     (flush_target_i[15:0]),
        .pc_o               (pc16),
        .ce_o               (ce16),
        .fetch_req_o        (req16),
        .redirect_pending_o (pend16),
        .misalign_o         (mis16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: reset > (enable off) > flush > accepted fetch > buffered branch.
    task automatic model_step(input logic r, s, a, b, input logic [31:0] bt,
                              input logic f, input logic [31:0] ft);
        logic adv;
        adv = m_ce && !s && a;
        if (r) begin
            m_pc = RV; m_ce = 1'b0; m_pv = 1'b0; m_pt = 32'h0;
        end else if (!m_ce) begin
            m_pc = RV; m_ce = 1'b1; m_pv = 1'b0;
        end else if (f) begin
            m_pc = ft; m_pv = 1'b0;
        end else if (adv) begin
            if (b)         m_pc = bt;
            else if (m_pv) m_pc = m_pt;
            else           m_pc = m_pc + 32'd4;
            m_pv = 1'b0;
        end else if (b) begin
            m_pv = 1'b1; m_pt = bt;
        end
        m_mis = !r && ALIGN_EN && ((m_pc % 32'd4) != 32'd0);
    endtask

    task automatic apply(input logic r, s, a, b, input logic [31:0] bt,
                         input logic f, input logic [31:0] ft);
        rst             = r;
        stall           = {5'($urandom_range(0, 31)), s};
        fetch_ack_i     = a;
        branch_flag_i   = b;
        branch_target_i = bt;
        flush_i         = f;
        flush_target_i  = ft;
        @(posedge clk);
        model_step(r, s, a, b, bt, f, ft);
        #1;
    endtask

    task automatic add(input logic r, s, a, b, input logic [31:0] bt, input logic f,
                       input logic [31:0] ft, input logic [31:0] epc, input logic ece,
                       input logic epend, input logic emis);
        vecs.push_back('{r, s, a, b, bt, f, ft, epc, ece, epend, emis});
    endtask

    initial begin
        rst = 1'b1; stall = 6'h00; fetch_ack_i = 1'b0; branch_flag_i = 1'b0;
        branch_target_i = 32'h0; flush_i = 1'b0; flush_target_i = 32'h0;
        m_pc = RV; m_ce = 1'b0; m_pv = 1'b0; m_pt = 32'h0; m_mis = 1'b0;

        //   r     s     a     b     bt            f     ft            pc            ce    pend  mis
        add(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        RV,           1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        RV,           1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        RV,           1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'hBFC00004, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'hBFC00008, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        32'hBFC00008, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'hBFC00008, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'hBFC00008, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h100,      1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h104,      1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        32'h104,      1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h380,      32'h380,      1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h384,      1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h20,       1'b0, 32'h0,        32'h20,       1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h20,       1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h20,       1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h24,       1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h500,      1'b1, 32'h600,      32'h600,      1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h604,      1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h700,      1'b1, 32'h800,      32'h800,      1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        32'hFFFFFFFC, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h00000000, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h1234FFFC, 1'b0, 32'h0,        32'h1234FFFC, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h12350000, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h40,       1'b0, 32'h0,        32'h12350000, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 32'h80,       1'b0, 32'h0,        32'h12350000, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h80,       1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'h90,       1'b0, 32'h0,        32'h80,       1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h90,       1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'hAAA0,     1'b0, 32'h0,        RV,           1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        RV,           1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h102,      1'b0, 32'h0,        32'h102,      1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h106,      1'b1, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h200,      32'h200,      1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h204,      1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        RV,           1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'h300,      1'b1, 32'h340,      RV,           1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'hBFC00004, 1'b1, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].bt, vecs[i].f, vecs[i].ft);
            check($sformatf("vec%0d pc", i),   pc_o,               vecs[i].e_pc);
            check($sformatf("vec%0d ce", i),   {31'd0, ce_o},      {31'd0, vecs[i].e_ce});
            check($sformatf("vec%0d req", i),  {31'd0, fetch_req_o}, {31'd0, vecs[i].e_ce});
            check($sformatf("vec%0d pend", i), {31'd0, redirect_pending_o}, {31'd0, vecs[i].e_pend});
            check($sformatf("vec%0d mis", i),  {31'd0, misalign_o}, {31'd0, vecs[i].e_mis & ALIGN_EN});
            check($sformatf("vec%0d pc16", i), {16'd0, pc16},      {16'd0, vecs[i].e_pc[15:0]});
        end

        for (int n = 0; n < 500; n++) begin
            logic        r, s, a, b, f;
            logic [31:0] bt, ft;
            r  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 3) != 0);
            b  = ($urandom_range(0, 3) == 0);
            f  = ($urandom_range(0, 9) == 0);
            bt = $urandom;
            ft = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) ft[1:0] = 2'b00;
            apply(r, s, a, b, bt, f, ft);
            check($sformatf("rnd%0d pc", n),   pc_o,               m_pc);
            check($sformatf("rnd%0d ce", n),   {31'd0, ce_o},      {31'd0, m_ce});
            check($sformatf("rnd%0d req", n),  {31'd0, fetch_req_o}, {31'd0, m_ce});
            check($sformatf("rnd%0d pend", n), {31'd0, redirect_pending_o}, {31'd0, m_pv});
            check($sformatf("rnd%0d mis", n),  {31'd0, misalign_o}, {31'd0, m_mis});
            check($sformatf("rnd%0d pc16", n), {16'd0, pc16},      {16'd0, m_pc[15:0]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
